nb_delay_pipe: RTL and testbench

Cycle-accurate, synthesizable stand-in for a nonblocking intra-assignment delay of the form `reg <= #(min:typ:max) expr`. It sits directly upstream of the value-checking stage in the delayed-assignment regression benches. Every accepted sample is transported, not inertially filtered, to the output after exactly D clock cycles, where D is the MIN, TYP or MAX delay selected at run time. A sticky `out_seen` flag lets the downstream checker tell "no value has arrived yet" (the x-state in simulation) from a real value.

---
 rtl/nb_delay_pipe.sv | 104 ++++++++++
 tb/tb_nb_delay_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nb_delay_pipe.sv
// Fixed-latency transport delay line: every accepted sample emerges exactly D_act
// cycles later, where D_act is one of MIN/TYP/MAX and may only change once the pipe is empty.
module nb_delay_pipe #(
    parameter int WIDTH   = 4,
    parameter int MIN_DLY = 2,
    parameter int TYP_DLY = 10,
    parameter int MAX_DLY = 17,
    localparam int CW     = $clog2(MAX_DLY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_seen,
    output logic [CW-1:0]    in_flight,
    output logic             busy
);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t                     state;
    logic [MAX_DLY:1]           vld_pipe;
    logic [MAX_DLY:1][WIDTH-1:0] dat_pipe;
    logic [CW-1:0]              d_act;
    logic [CW-1:0]              d_sel;
    logic [CW-1:0]              fl_nxt;
    logic [WIDTH-1:0]           last_data;
    logic                       seen;
    logic                       accept;

    always_comb begin
        case (sel)
            2'd0:    d_sel = CW'(MIN_DLY);
            2'd2:    d_sel = CW'(MAX_DLY);
            default: d_sel = CW'(TYP_DLY);
        endcase
    end

    assign in_ready  = (state == RUN) && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_pipe[d_act];
    assign out_data  = out_valid ? dat_pipe[d_act] : last_data;
    assign out_seen  = seen || out_valid;
    assign busy      = (state == DRAIN) || (in_flight != '0);

    always_comb begin
        fl_nxt = in_flight;
        if (accept && !out_valid)
            fl_nxt = in_flight + CW'(1);
        else if (!accept && out_valid)
            fl_nxt = in_flight - CW'(1);
    end

    // Data needs no reset: nothing reads a stage unless its valid bit is set.
    always_ff @(posedge clk) begin
        dat_pipe[1] <= in_data;
        for (int i = 2; i <= MAX_DLY; i++)
            dat_pipe[i] <= dat_pipe[i-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            last_data <= '0;
            seen      <= 1'b0;
            in_flight <= '0;
            state     <= RUN;
            d_act     <= d_sel;
        end else begin
            // Valid bits past the tap are dropped so a later, longer D_act cannot re-see them.
            vld_pipe[1] <= accept;
            for (int i = 2; i <= MAX_DLY; i++)
                vld_pipe[i] <= vld_pipe[i-1] && (CW'(i) <= d_act);
            if (out_valid) begin
                last_data <= dat_pipe[d_act];
                seen      <= 1'b1;
            end
            in_flight <= fl_nxt;
            case (state)
                RUN: begin
                    if (d_sel != d_act) begin
                        if (in_flight == '0 && !accept)
                            d_act <= d_sel;
                        else
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Exit on the cycle the last sample emerges so RUN resumes right after.
                    if (fl_nxt == '0) begin
                        d_act <= d_sel;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_nb_delay_pipe.sv
// Directed bench for nb_delay_pipe: the driver queues expected {cycle, data} on each
// accept; a negedge monitor pops and compares whenever out_valid is seen.
module tb_nb_delay_pipe;

    localparam int WIDTH = 4;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_seen;
    logic [CW-1:0]    in_flight;
    logic             busy;

    nb_delay_pipe #(.WIDTH(4), .MIN_DLY(2), .TYP_DLY(10), .MAX_DLY(17)) dut (
        .clk(clk), .reset(reset), .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
        .out_seen(out_seen), .in_flight(in_flight), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_data), 32'hDEAD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("emerge_cycle", 32'(cyc), 32'(e.cyc));
                    chk("emerge_data", 32'(out_data), 32'(e.data));
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("missing_out_valid", 32'(out_valid), 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int dly(input logic [1:0] s);
        return (s == 2'd0) ? 2 : (s == 2'd2) ? 17 : 10;
    endfunction

    // Offer one sample this cycle, expecting it to be accepted.
    task automatic put(input logic [WIDTH-1:0] d);
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        chk("in_ready_on_accept", 32'(in_ready), 32'd1);
        e.cyc  = cyc + dly(sel);
        e.data = d;
        sb.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int peak;
        reset = 1'b1; sel = 2'd0; in_valid = 1'b0; in_data = '0;
        step(); step();
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_seen", 32'(out_seen), 32'd0);
        chk("rst_in_flight", 32'(in_flight), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // MIN latency, out_seen timing, out_data hold
        c0 = cyc;
        chk("seen_c0", 32'(out_seen), 32'd0);
        put(4'h1);
        chk("seen_c1", 32'(out_seen), 32'd0);
        chk("flight_c1", 32'(in_flight), 32'd1);
        step();
        chk("seen_c2", 32'(out_seen), 32'd1);
        chk("valid_c2", 32'(out_valid), 32'd1);
        for (int i = 3; i <= 15; i++) begin
            step();
            chk("hold_data", 32'(out_data), 32'h1);
            chk("hold_novalid", 32'(out_valid), 32'd0);
        end

        // TYP and MAX latency
        sel = 2'd1; step();
        put(4'h5);
        repeat (12) step();
        sel = 2'd2; step();
        put(4'h5);
        repeat (19) step();

        // MIN back-to-back stream
        sel = 2'd0; step();
        peak = 0;
        for (int i = 0; i < 20; i++) begin
            put(4'(i));
            if (int'(in_flight) > peak) peak = int'(in_flight);
        end
        repeat (4) step();
        chk("stream_peak", 32'(peak), 32'd2);
        chk("stream_idle_flight", 32'(in_flight), 32'd0);

        // Delay change with samples in flight forces DRAIN
        sel = 2'd2; step();
        c0 = cyc;
        put(4'hA);
        put(4'hB);
        step();
        sel = 2'd0; step();
        for (int c = 4; c <= 18; c++) begin
            if (c == 5) begin in_valid = 1'b1; in_data = 4'hC; end
            chk("drain_in_ready", 32'(in_ready), 32'd0);
            chk("drain_busy", 32'(busy), 32'd1);
            step();
        end
        chk("drain_exit_cycle", 32'(cyc - c0), 32'd19);
        put(4'hC);
        repeat (4) step();

        // Reset discards in-flight samples
        sel = 2'd1; step();
        c0 = cyc;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin in_data = 4'(7 + i); step(); end
        in_valid = 1'b0;
        chk("pre_reset_flight", 32'(in_flight), 32'd3);
        step();
        reset = 1'b1; step();
        reset = 1'b0;
        #1;
        chk("post_reset_flight", 32'(in_flight), 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk("post_reset_novalid", 32'(out_valid), 32'd0);
            chk("post_reset_seen", 32'(out_seen), 32'd0);
            step();
        end

        // Equal-delay sel change (1 -> 3) never drains
        c0 = cyc;
        put(4'h9);
        step();
        sel = 2'd3;
        for (int i = 0; i < 4; i++) begin
            chk("equal_sel_ready", 32'(in_ready), 32'd1);
            step();
        end
        put(4'h6);
        repeat (14) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
